// File: rtl/fifo_arbiter_if.sv
// Requester/fifo-side signal bundle for fifo_arbiter.
// The arbiter uses the slave modport; requesters and the fifo use the master modport.
interface fifo_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned N    = 32
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]   REQ;
  logic [NREQ*N-1:0] REQ_DATA;
  logic [NREQ-1:0]   LOCK;
  logic [NREQ-1:0]   GNT;
  logic              FIFO_FULL;
  logic              FIFO_POP;
  logic              FIFO_PUSH;
  logic [N-1:0]      FIFO_DIN;
  logic [IW-1:0]     OWNER;
  logic              OWNER_V;
  logic              LOCKED;

  modport master (
    output REQ, REQ_DATA, LOCK, FIFO_FULL, FIFO_POP,
    input  GNT, FIFO_PUSH, FIFO_DIN, OWNER, OWNER_V, LOCKED
  );

  modport slave (
    input  REQ, REQ_DATA, LOCK, FIFO_FULL, FIFO_POP,
    output GNT, FIFO_PUSH, FIFO_DIN, OWNER, OWNER_V, LOCKED
  );
endinterface

// File: rtl/fifo_arbiter.sv
// Round-robin arbiter sharing one single-entry fifo between NREQ requesters, with owner tracking.
// Burst lock is built only when FIFO_ARB_LOCK_EN is defined; otherwise LOCK is ignored.
module fifo_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned N    = 32
) (
  input logic           clk,
  input logic           reset_n,
  fifo_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(NREQ);

  // (a + b) mod NREQ for a, b < NREQ; NREQ need not be a power of two.
  function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= NREQ) s = s - NREQ;
    return s[IW-1:0];
  endfunction

  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_ptr_d;
  logic [IW-1:0]   r_owner;
  logic            r_owner_v;
  logic            w_lock_v;
  logic [IW-1:0]   w_lock_idx;
  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [NREQ-1:0] w_gnt;
  logic            w_push;
  logic [N-1:0]    w_din;

`ifdef FIFO_ARB_LOCK_EN
  logic          r_lock_v;
  logic          w_lock_v_d;
  logic [IW-1:0] r_lock_idx;
  logic [IW-1:0] w_lock_idx_d;

  assign w_lock_v   = r_lock_v;
  assign w_lock_idx = r_lock_idx;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lock_v   <= 1'b0;
      r_lock_idx <= '0;
    end else begin
      r_lock_v   <= w_lock_v_d;
      r_lock_idx <= w_lock_idx_d;
    end
  end
`else
  logic w_unused_lock;

  assign w_lock_v      = 1'b0;
  assign w_lock_idx    = '0;
  assign w_unused_lock = ^bus.LOCK;
`endif

  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_elig[i] = bus.REQ[i] && (!w_lock_v || (32'(w_lock_idx) == i));
    end
  end

  // First eligible requester at or above ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_found && w_elig[idx_add(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = idx_add(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_gnt = '0;
    w_din = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_gnt[i] = w_found && !bus.FIFO_FULL && (32'(w_win) == i);
      w_din    = w_din | ({N{w_gnt[i]}} & bus.REQ_DATA[i*N +: N]);
    end
  end

  assign w_push = |w_gnt;

  always_comb begin
    w_ptr_d = r_ptr;
    if (w_push) w_ptr_d = idx_add(w_win, 1);
`ifdef FIFO_ARB_LOCK_EN
    w_lock_v_d   = r_lock_v;
    w_lock_idx_d = r_lock_idx;
    if (w_push) begin
      if (bus.LOCK[w_win]) begin
        // Taking or keeping the lock parks the pointer on the owner.
        w_lock_v_d   = 1'b1;
        w_lock_idx_d = w_win;
        w_ptr_d      = w_win;
      end else begin
        w_lock_v_d = 1'b0;
      end
    end else if (r_lock_v && !bus.REQ[r_lock_idx]) begin
      w_lock_v_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr     <= '0;
      r_owner   <= '0;
      r_owner_v <= 1'b0;
    end else begin
      r_ptr <= w_ptr_d;
      if (w_push) begin
        r_owner   <= w_win;
        r_owner_v <= 1'b1;
      end else if (bus.FIFO_POP) begin
        r_owner_v <= 1'b0;
      end
    end
  end

  assign bus.GNT       = w_gnt;
  assign bus.FIFO_PUSH = w_push;
  assign bus.FIFO_DIN  = w_din;
  assign bus.OWNER     = r_owner;
  assign bus.OWNER_V   = r_owner_v;
  assign bus.LOCKED    = w_lock_v;
endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed bench for fifo_arbiter: a 2-requester and a 4-requester instance, each with a
// behavioural single-entry fifo whose FULL folds in the same-cycle POP.
module tb_fifo_arbiter;
  localparam int unsigned W = 8;
`ifdef FIFO_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;
  bit   inv_en = 1'b0;

  always #5 clk = ~clk;

  fifo_arbiter_if #(.NREQ(2), .N(W)) bus2 ();
  fifo_arbiter_if #(.NREQ(4), .N(W)) bus4 ();

  fifo_arbiter #(.NREQ(2), .N(W)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));
  fifo_arbiter #(.NREQ(4), .N(W)) dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  logic f2_v;
  logic f4_v;

  assign bus2.FIFO_FULL = f2_v & ~bus2.FIFO_POP;
  assign bus4.FIFO_FULL = f4_v & ~bus4.FIFO_POP;

  always @(posedge clk) begin
    if (!reset_n) begin
      f2_v <= 1'b0;
      f4_v <= 1'b0;
    end else begin
      f2_v <= bus2.FIFO_PUSH | (f2_v & ~bus2.FIFO_POP);
      f4_v <= bus4.FIFO_PUSH | (f4_v & ~bus4.FIFO_POP);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // OWNER_V must track the fifo's !EMPTY every cycle.
  always @(negedge clk) begin
    if (inv_en) begin
      check("ownv_vs_fifo2", 32'(bus2.OWNER_V), 32'(f2_v));
      check("ownv_vs_fifo4", 32'(bus4.OWNER_V), 32'(f4_v));
    end
  end

  initial begin
    reset_n       = 1'b0;
    bus2.REQ      = '0;
    bus2.REQ_DATA = {8'hB1, 8'hA0};
    bus2.LOCK     = '0;
    bus2.FIFO_POP = 1'b0;
    bus4.REQ      = '0;
    bus4.REQ_DATA = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus4.LOCK     = '0;
    bus4.FIFO_POP = 1'b0;
    step();
    step();
    #1;
    check("rst_gnt", 32'(bus2.GNT), 0);
    check("rst_ownv", 32'(bus2.OWNER_V), 0);
    check("rst_owner", 32'(bus2.OWNER), 0);
    check("rst_locked", 32'(bus2.LOCKED), 0);
    check("rst_ownv4", 32'(bus4.OWNER_V), 0);
    reset_n = 1'b1;
    inv_en  = 1'b1;

    // Alternating round-robin at full throughput.
    bus2.REQ      = 2'b11;
    bus2.FIFO_POP = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_gnt", 32'(bus2.GNT), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_din", 32'(bus2.FIFO_DIN), (k % 2 == 0) ? 32'hA0 : 32'hB1);
      if (k > 0) check("rr_owner", 32'(bus2.OWNER), (k % 2 == 0) ? 32'h1 : 32'h0);
      step();
    end
    bus2.REQ = 2'b00;
    #1;
    check("idle_push", 32'(bus2.FIFO_PUSH), 0);
    check("idle_din", 32'(bus2.FIFO_DIN), 0);
    step();
    #1;
    check("drain_ownv", 32'(bus2.OWNER_V), 0);
    check("drain_owner_hold", 32'(bus2.OWNER), 1);

    // Stall on full, then push-while-pop releases it in the same cycle.
    bus2.FIFO_POP = 1'b0;
    bus2.REQ      = 2'b01;
    #1;
    check("fill_gnt", 32'(bus2.GNT), 1);
    step();
    for (int k = 0; k < 2; k++) begin
      #1;
      check("full_gnt", 32'(bus2.GNT), 0);
      check("full_push", 32'(bus2.FIFO_PUSH), 0);
      step();
    end
    bus2.FIFO_POP = 1'b1;
    #1;
    check("pop_gnt", 32'(bus2.GNT), 1);
    check("pop_din", 32'(bus2.FIFO_DIN), 32'hA0);
    step();
    check("pop_owner", 32'(bus2.OWNER), 0);
    check("pop_ownv", 32'(bus2.OWNER_V), 1);
    bus2.REQ = 2'b11;
    #1;
    check("ptr_after_stall", 32'(bus2.GNT), 2);
    step();

    // One entry held for five cycles, then popped.
    bus2.REQ = 2'b00;
    step();
    bus2.FIFO_POP = 1'b0;
    bus2.REQ      = 2'b10;
    #1;
    check("hold_gnt", 32'(bus2.GNT), 2);
    step();
    bus2.REQ = 2'b00;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("hold_ownv", 32'(bus2.OWNER_V), 1);
      check("hold_owner", 32'(bus2.OWNER), 1);
      step();
    end
    bus2.FIFO_POP = 1'b1;
    step();
    bus2.FIFO_POP = 1'b0;
    #1;
    check("hold_popped", 32'(bus2.OWNER_V), 0);

    // Burst lock on requester 1 for three grants, released on the fourth.
    bus2.FIFO_POP = 1'b1;
    bus2.REQ      = 2'b01;
    #1;
    check("lk_pre", 32'(bus2.GNT), 1);
    step();
    bus2.REQ = 2'b11;
    for (int k = 0; k < 4; k++) begin
      bus2.LOCK = (k < 3) ? 2'b10 : 2'b00;
      #1;
      check("lk_gnt", 32'(bus2.GNT), (LockEn || k % 2 == 0) ? 32'h2 : 32'h1);
      step();
      check("lk_locked", 32'(bus2.LOCKED), 32'(LockEn && k < 3));
    end
    bus2.LOCK = 2'b00;
    #1;
    check("lk_release", 32'(bus2.GNT), LockEn ? 32'h1 : 32'h2);
    step();

    // Abandon: dropping REQ of the lock holder clears the lock, pointer untouched.
    bus2.REQ = 2'b01;
    #1;
    check("ab_pre", 32'(bus2.GNT), 1);
    step();
    bus2.REQ  = 2'b11;
    bus2.LOCK = 2'b10;
    #1;
    check("ab_gnt", 32'(bus2.GNT), 2);
    step();
    check("ab_locked", 32'(bus2.LOCKED), 32'(LockEn));
    bus2.REQ  = 2'b01;
    bus2.LOCK = 2'b00;
    #1;
    check("ab_drop_gnt", 32'(bus2.GNT), LockEn ? 32'h0 : 32'h1);
    step();
    check("ab_unlocked", 32'(bus2.LOCKED), 0);
    bus2.REQ = 2'b11;
    #1;
    check("ab_ptr", 32'(bus2.GNT), 2);
    step();

    // Reset while locked with an entry buffered.
    bus2.REQ  = 2'b10;
    bus2.LOCK = 2'b10;
    #1;
    check("rb_gnt", 32'(bus2.GNT), 2);
    step();
    bus2.FIFO_POP = 1'b0;
    #1;
    check("rb_locked", 32'(bus2.LOCKED), 32'(LockEn));
    check("rb_ownv", 32'(bus2.OWNER_V), 1);
    reset_n = 1'b0;
    step();
    reset_n   = 1'b1;
    bus2.REQ  = 2'b11;
    bus2.LOCK = 2'b00;
    #1;
    check("rb_locked0", 32'(bus2.LOCKED), 0);
    check("rb_ownv0", 32'(bus2.OWNER_V), 0);
    check("rb_owner0", 32'(bus2.OWNER), 0);
    check("rb_first", 32'(bus2.GNT), 1);
    step();
    bus2.REQ = 2'b00;

    // Four requesters: wrap-around from ptr=3.
    bus4.FIFO_POP = 1'b1;
    bus4.REQ      = 4'b0100;
    #1;
    check("w4_setup", 32'(bus4.GNT), 32'h4);
    step();
    bus4.REQ = 4'b0101;
    #1;
    check("w4_wrap", 32'(bus4.GNT), 32'h1);
    check("w4_wrap_din", 32'(bus4.FIFO_DIN), 32'hA0);
    step();
    check("w4_owner", 32'(bus4.OWNER), 0);
    check("w4_next", 32'(bus4.GNT), 32'h4);
    check("w4_next_din", 32'(bus4.FIFO_DIN), 32'hC2);
    step();
    bus4.REQ = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("w4_sweep", 32'(bus4.GNT), 32'h1 << ((3 + k) % 4));
      step();
      check("w4_sweep_owner", 32'(bus4.OWNER), 32'((3 + k) % 4));
    end
    bus4.REQ = 4'b0000;
    step();

    inv_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
